frame_max_sched: RTL and testbench

Round-robin scheduler that shares one max-finding reduction datapath among NREQ requesters. It grants the datapath to one requester at a time and clears the datapath. It then streams exactly FRAME_LEN samples from the granted lane into the datapath, waits for the datapath's result and reports it tagged with the requester ID. It sits between the sample producers and the single maximum-search unit.

---
 rtl/frame_max_sched.sv | 199 +++++++++++++++++++
 tb/tb_frame_max_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_max_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_max_sched
// Purpose  : Round-robin scheduler that feeds one requester's frame at a time
//            into a shared max-finding datapath and reports the tagged result.
// Revision : 1.0 - initial release
// ============================================================================
module frame_max_sched #(
    parameter int W         = 8,
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 20,
    parameter int TIMEOUT   = 16
) (
    input  logic                     CLK,
    input  logic                     RESETZ,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*W-1:0]        req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          req_ready,
    output logic                     dp_clr,
    output logic                     dp_valid,
    output logic [W-1:0]             dp_data,
    input  logic                     dp_done,
    input  logic [W-1:0]             dp_result,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [W-1:0]             res_max,
    output logic                     res_err,
    output logic                     busy
);

    localparam int c_ID_W  = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(FRAME_LEN + 1);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_gid;
    logic [c_ID_W-1:0]   r_last;
    logic [c_ID_W-1:0]   w_sel;
    logic [c_ID_W-1:0]   w_idx;
    logic                w_any;
    logic [NREQ-1:0]     w_oh;
    logic [W-1:0]        w_lane_data;
    logic                w_lane_valid;
    logic                w_lane_req;
    logic                w_acc;
    logic                w_abort;
    logic                w_tmo;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_dp_valid;
    logic [W-1:0]        r_dp_data;
    logic [c_ID_W-1:0]   r_res_id;
    logic [W-1:0]        r_res_max;
    logic                r_res_err;

    // Scan from last_gnt+NREQ down to last_gnt+1 so the closest requester wins.
    always_comb begin
        w_sel       = '0;
        w_any       = 1'b0;
        w_idx       = '0;
        w_oh        = '0;
        w_lane_data = '0;
        w_oh[r_gid] = 1'b1;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = c_ID_W'((int'(r_last) + k) % NREQ);
            if (req[w_idx]) begin
                w_sel = w_idx;
                w_any = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (r_gid == c_ID_W'(i)) begin
                w_lane_data = req_data[i*W +: W];
            end
        end
    end

    assign w_lane_valid = req_valid[r_gid];
    assign w_lane_req   = req[r_gid];
    assign w_acc        = (r_state == S_STREAM) && w_lane_valid;
    assign w_abort      = (r_state == S_STREAM) && !w_lane_req;
    assign w_tmo        = (r_timer == c_TMR_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RESETZ) begin
        if (!RESETZ) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        req_ready   = '0;
        dp_clr      = 1'b0;
        res_valid   = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                gnt         = w_oh;
                dp_clr      = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                gnt       = w_oh;
                req_ready = w_oh;
                if (w_abort) begin
                    w_state_nxt = S_REPORT;
                end else if (w_acc && (r_cnt == c_CNT_W'(FRAME_LEN - 1))) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                gnt = w_oh;
                if (dp_done || w_tmo) w_state_nxt = S_REPORT;
            end
            S_REPORT: begin
                res_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETZ) begin
        if (!RESETZ) begin
            r_gid      <= '0;
            r_last     <= c_ID_W'(NREQ - 1);
            r_cnt      <= '0;
            r_timer    <= '0;
            r_dp_valid <= 1'b0;
            r_dp_data  <= '0;
            r_res_id   <= '0;
            r_res_max  <= '0;
            r_res_err  <= 1'b0;
        end else begin
            r_dp_valid <= w_acc;
            if (w_acc) r_dp_data <= w_lane_data;
            if (r_state != S_WAIT) r_timer <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) r_gid <= w_sel;
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                end
                S_STREAM: begin
                    if (w_acc) r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_abort) begin
                        r_res_id  <= r_gid;
                        r_res_max <= '0;
                        r_res_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // dp_done wins over a timeout landing on the same cycle
                    if (dp_done) begin
                        r_res_id  <= r_gid;
                        r_res_max <= dp_result;
                        r_res_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_res_id  <= r_gid;
                        r_res_max <= '0;
                        r_res_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                S_REPORT: begin
                    r_last <= r_gid;
                end
                default: ;
            endcase
        end
    end

    assign dp_valid = r_dp_valid;
    assign dp_data  = r_dp_data;
    assign res_id   = r_res_id;
    assign res_max  = r_res_max;
    assign res_err  = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_max_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_max_sched
// Purpose  : Randomized frame traffic against a frame-level scheduler model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_max_sched;

    localparam int W         = 8;
    localparam int NREQ      = 4;
    localparam int FRAME_LEN = 20;
    localparam int TIMEOUT   = 16;

    logic                    CLK = 1'b0;
    logic                    RESETZ;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*W-1:0]       req_data;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         req_ready;
    logic                    dp_clr;
    logic                    dp_valid;
    logic [W-1:0]            dp_data;
    logic                    dp_done;
    logic [W-1:0]            dp_result;
    logic                    res_valid;
    logic [$clog2(NREQ)-1:0] res_id;
    logic [W-1:0]            res_max;
    logic                    res_err;
    logic                    busy;

    int n_chk  = 0;
    int n_pass = 0;
    int m_last = NREQ - 1;
    int cyc    = 0;

    frame_max_sched #(
        .W(W), .NREQ(NREQ), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .CLK(CLK), .RESETZ(RESETZ), .req(req), .req_valid(req_valid),
        .req_data(req_data), .gnt(gnt), .req_ready(req_ready), .dp_clr(dp_clr),
        .dp_valid(dp_valid), .dp_data(dp_data), .dp_done(dp_done),
        .dp_result(dp_result), .res_valid(res_valid), .res_id(res_id),
        .res_max(res_max), .res_err(res_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // gap: 0 none, 1 alternate cycles, 2 random. lat<0: datapath never answers.
    task automatic do_frame(input logic [NREQ-1:0] mask, input int gap, input int ff_pos,
                            input bit fixed, input int drop_after, input int lat,
                            input int rst_after);
        int g, n_acc, pulses, last_pc, wait_n;
        bit done, aborted, ctl_bad, rdy_bad, stray, v;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_max, dpm, s;
        logic [NREQ-1:0] oh;
        g = -1;
        for (int k = 1; k <= NREQ; k++)
            if (g < 0 && mask[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
        oh = '0; oh[g] = 1'b1;
        n_acc = 0; pulses = 0; last_pc = 0; wait_n = 0;
        done = 0; aborted = 0; ctl_bad = 0; rdy_bad = 0;
        exp_max = '0; dpm = '0;
        req = mask; req_valid = '0; dp_done = 1'b0;
        tick();
        chk("gnt", gnt, oh);
        chk("dp_clr", dp_clr, 1);
        chk("rdy_clear", req_ready, 0);
        tick();
        for (int c = 0; c < 400 && !done; c++) begin
            if (dp_valid) begin
                if (exp_q.size() == 0) chk("dp_extra", dp_valid, 0);
                else chk("dp_data", dp_data, exp_q.pop_front());
                pulses++;
                if (dp_data > dpm) dpm = dp_data;
                last_pc = cyc;
            end
            if (busy && !res_valid && (gnt !== oh || dp_clr)) ctl_bad = 1;
            if ((req_ready & ~oh) != '0) ctl_bad = 1;
            if (res_valid) begin
                done = 1;
            end else begin
                if (rst_after >= 0 && n_acc == rst_after) begin
                    RESETZ = 1'b0; req = '0; req_valid = '0;
                    #1;
                    chk("rst_async", {gnt, req_ready, dp_clr, dp_valid, dp_data, res_valid,
                                      res_id, res_max, res_err, busy}, 0);
                    @(posedge CLK);
                    #1;
                    RESETZ = 1'b1;
                    stray = 0;
                    repeat (4) begin
                        tick();
                        if (res_valid || busy || dp_valid) stray = 1;
                    end
                    chk("rst_quiet", stray, 0);
                    m_last = NREQ - 1;
                    return;
                end
                // datapath model: answers lat cycles after the last sample
                dp_done = 1'b0;
                if (pulses == FRAME_LEN && lat >= 0) begin
                    if (wait_n == lat) begin
                        dp_done = 1'b1;
                        dp_result = dpm;
                    end
                    wait_n++;
                end
                if (req_ready[g] && n_acc >= FRAME_LEN) rdy_bad = 1;
                for (int i = 0; i < NREQ; i++) begin
                    req_data[i*W +: W] = W'($urandom);
                    req_valid[i] = 1'($urandom_range(0, 1));
                end
                if (drop_after >= 0 && n_acc == drop_after) begin
                    req[g] = 1'b0;
                    aborted = 1;
                end
                v = (gap == 0) ? 1'b1 : (gap == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
                if (req[g] && req_ready[g] && v) begin
                    if (fixed) s = W'(5 + n_acc);
                    else if (n_acc == ff_pos) s = 8'hFF;
                    else if (ff_pos >= 0) s = W'($urandom_range(0, 254));
                    else s = W'($urandom);
                    req_data[g*W +: W] = s;
                    req_valid[g] = 1'b1;
                    exp_q.push_back(s);
                    if (s > exp_max) exp_max = s;
                    n_acc++;
                end else begin
                    req_valid[g] = 1'b0;
                end
                tick();
            end
        end
        req_valid = '0;
        dp_done = 1'b0;
        chk("rpt_seen", done, 1);
        if (done) begin
            chk("res_id", res_id, g);
            chk("res_err", res_err, 32'(aborted || lat < 0));
            if (!aborted) begin
                chk("res_max", res_max, (lat < 0) ? 0 : exp_max);
                chk("rpt_lat", cyc - last_pc, (lat < 0) ? TIMEOUT : lat + 1);
            end
            chk("n_pulses", pulses, n_acc);
            chk("ctl", ctl_bad, 0);
            chk("rdy_drop", rdy_bad, 0);
            m_last = g;
            tick();
            chk("idle_gap", {busy, gnt, dp_valid, res_valid}, 0);
        end
    endtask

    initial begin
        int gp, lt, dr, r;
        logic [NREQ-1:0] mk;
        RESETZ = 1'b0; req = '0; req_valid = '0; req_data = '0;
        dp_done = 1'b0; dp_result = '0;
        #12;
        chk("rst_state", {gnt, req_ready, dp_clr, dp_valid, dp_data, res_valid,
                          res_id, res_max, res_err, busy}, 0);
        @(posedge CLK);
        #1;
        RESETZ = 1'b1;
        // all requesters held: grants 0,1,2,3,0
        repeat (5) do_frame(4'hF, 0, -1, 0, -1, $urandom_range(0, 4), -1);
        do_frame(4'b0001, 0, -1, 1, -1, 0, -1);
        do_frame(4'b0100, 1, 13, 0, -1, 2, -1);
        do_frame(4'b1000, 0, -1, 0, -1, -1, -1);
        do_frame(4'b1111, 0, -1, 0, -1, 1, -1);
        do_frame(4'b0010, 0, -1, 0, 7, 0, -1);
        do_frame(4'b1111, 2, -1, 0, -1, 3, -1);
        repeat (8) begin
            mk = NREQ'($urandom_range(1, 15));
            gp = $urandom_range(0, 2);
            r  = $urandom_range(0, 6);
            lt = (r == 6) ? -1 : r;
            dr = ($urandom_range(0, 4) == 0) ? $urandom_range(1, FRAME_LEN - 1) : -1;
            do_frame(mk, gp, -1, 0, dr, lt, -1);
        end
        do_frame(4'b0001, 0, -1, 0, -1, 0, -1);
        do_frame(4'b0010, 0, -1, 0, -1, 0, 10);
        do_frame(4'b1111, 0, -1, 0, -1, 0, -1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
